count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Sequence checker that sits directly downstream of the 3-bit up counter and consumes its count output. Each enabled cycle it verifies that the count advanced by exactly +1 modulo 2^WIDTH, counts wrap-arounds and errors, and reports lock status. Used as an in-design monitor and as the self-checking stage behind the counter in system benches.

## Interface
- WIDTH, 3: width of the observed count.
- WRAP_W, 8: width of the wrap counter.
- ERR_W, 4: width of the saturating error counter.

- clk  in  1  rising-edge clock, shared with the upstream counter.
- rst  in  1  asynchronous, active-high reset.
- q  in  WIDTH  observed count (upstream counter Q).
- en  in  1  sample enable; 0 = stall, nothing checked or updated.
- clr  in  1  synchronous clear of statistics and state.
- locked  out  1  checker is tracking the sequence.
- err  out  1  one-cycle pulse on a sequence mismatch.
- err_sticky  out  1  set by any mismatch, cleared only by clr/rst.
- wrap  out  1  one-cycle pulse on a valid max→0 transition.
- wrap_cnt  out  WRAP_W  number of valid wraps, modulo 2^WRAP_W.
- err_cnt  out  ERR_W  number of mismatches, saturating at 2^ERR_W−1.

## Operation
- Registered state: prev[WIDTH-1:0] and FSM {ACQUIRE, TRACK, FAULT}.
- rst=1 (async): state=ACQUIRE, prev=0, all outputs 0.
- Priority per edge: rst > clr > en. en=0: all state held, err/wrap return to 0.
- clr=1: state=ACQUIRE, prev=0, wrap_cnt=0, err_cnt=0, err_sticky=0, locked=0; no err/wrap pulse that cycle, regardless of q/en.
- ACQUIRE, en=1: prev<=q, state<=TRACK, locked<=1. No check on this sample.
- TRACK, en=1: exp = prev+1 truncated to WIDTH bits.
  - q==exp: prev<=q. If prev==2^WIDTH−1 (so q==0): wrap pulse, wrap_cnt+1 (rolls over to 0).
  - q!=exp: err pulse, err_sticky<=1, err_cnt+1 unless already at max; prev<=q; next state per Configuration.
- FAULT: locked=0, q ignored, no pulses, counters frozen; exits only via clr or rst.
- Upstream counter reset mid-run (q jumps to 0 from anything other than max) is a mismatch. q holding its value with en=1 is a mismatch.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Sample taken at edge N: counters, err_sticky, and locked update at edge N; err and wrap are high from edge N to edge N+1 only.
- First check happens at the second enabled edge after reset or clr. locked rises at the first enabled edge.
- Check latency is 1 cycle. Back-to-back mismatches give consecutive err pulses, one per enabled edge.

## Configuration
- COUNT_SEQ_RESYNC_EN defined: on a mismatch, stay in TRACK with prev<=q. The checker relocks on the observed value and keeps checking; locked stays 1.
- Not defined: on a mismatch, go to FAULT and drop locked at the same edge. FAULT is never reached when the macro is defined.

## Test plan
- Reset, then en=1 and q=0..7,0..7,0,1 on successive edges → locked=1 after the first edge; two wrap pulses; wrap_cnt=2; err_cnt=0; err never high.
- Locked, q=3,4,6,7 → single err pulse at the edge sampling 6; err_cnt=1; err_sticky=1. Without the macro, locked=0 and 7 is ignored. With the macro, 7 gives no error and locked stays 1.
- Macro defined, q held at 2 for 20 enabled edges after lock → 19 err pulses; err_cnt saturates at 15 and stays.
- Locked at q=5, then en=0 for 4 cycles while q changes arbitrarily, then en=1 with q=6 → no err; prev=6; counters unchanged.
- Without the macro, in FAULT with err_cnt=1, assert clr and en together with q=3 → all counters 0, err_sticky=0, no pulse. Next enabled edges with q=4,5 → locked=1, no err.
- Running sequence; assert rst mid-cycle between edges → all outputs 0 immediately, without waiting for a clock edge. Release rst → ACQUIRE behaviour resumes.

Source files
------------

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - +1 modulo 2^WIDTH sequence checker for the upstream counter
// Optional COUNT_SEQ_RESYNC_EN: relock on the observed value after a mismatch instead of entering FAULT.
module count_seq_checker #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  q,
  input  logic              en,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [1:0] ACQUIRE = 2'd0;
  localparam logic [1:0] TRACK   = 2'd1;
  localparam logic [1:0] FAULT   = 2'd2;

  localparam logic [WIDTH-1:0]  Q_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  Q_MAX    = '1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_q;

  assign exp_q  = prev + Q_ONE;
  // locked is a pure decode of the state register, so it stays registered
  assign locked = (state == TRACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACQUIRE;
      prev       <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      wrap       <= 1'b0;
      wrap_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      err  <= 1'b0;
      wrap <= 1'b0;
      if (clr) begin
        state      <= ACQUIRE;
        prev       <= '0;
        err_sticky <= 1'b0;
        wrap_cnt   <= '0;
        err_cnt    <= '0;
      end else if (en) begin
        case (state)
          ACQUIRE: begin
            prev  <= q;
            state <= TRACK;
          end
          TRACK: begin
            prev <= q;
            if (q == exp_q) begin
              if (prev == Q_MAX) begin
                wrap     <= 1'b1;
                wrap_cnt <= wrap_cnt + WRAP_ONE;
              end
            end else begin
              err        <= 1'b1;
              err_sticky <= 1'b1;
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_ONE;
`ifdef COUNT_SEQ_RESYNC_EN
              state <= TRACK;
`else
              state <= FAULT;
`endif
            end
          end
          default: begin
            // FAULT holds everything until clr or rst
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - directed self-checking bench for count_seq_checker
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] q   = '0;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic       locked, err, err_sticky, wrap;
  logic [7:0] wrap_cnt;
  logic [3:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int nerr  = 0;
  int nwrap = 0;

  count_seq_checker dut (
    .clk(clk), .rst(rst), .q(q), .en(en), .clr(clr),
    .locked(locked), .err(err), .err_sticky(err_sticky), .wrap(wrap),
    .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one edge with the given inputs; outputs sampled 1 time unit after the edge
  task automatic step(input logic e, input logic [2:0] qv);
    en = e;
    q  = qv;
    @(posedge clk);
    #1;
    if (err === 1'b1) nerr++;
    if (wrap === 1'b1) nwrap++;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step(1'b1, 3'd0);
    clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, {31'd0, locked}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
    check({tag, "_sticky"}, {31'd0, err_sticky}, 0);
    check({tag, "_wrap"}, {31'd0, wrap}, 0);
    check({tag, "_wrap_cnt"}, {24'd0, wrap_cnt}, 0);
    check({tag, "_err_cnt"}, {28'd0, err_cnt}, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // two full passes plus 0,1
    step(1'b1, 3'd0);
    check("lock_first_edge", {31'd0, locked}, 1);
    for (int i = 1; i < 18; i++) step(1'b1, 3'(i % 8));
    check("seq_wrap_pulses", nwrap, 2);
    check("seq_wrap_cnt", {24'd0, wrap_cnt}, 2);
    check("seq_err_cnt", {28'd0, err_cnt}, 0);
    check("seq_err_pulses", nerr, 0);
    check("seq_locked", {31'd0, locked}, 1);

    // 2,3,4 continue from prev=1, then skip to 6
    nerr = 0;
    step(1'b1, 3'd2);
    step(1'b1, 3'd3);
    step(1'b1, 3'd4);
    check("skip_no_err_before", nerr, 0);
    step(1'b1, 3'd6);
    check("skip_err_pulse", {31'd0, err}, 1);
    check("skip_err_cnt", {28'd0, err_cnt}, 1);
    check("skip_sticky", {31'd0, err_sticky}, 1);
    step(1'b1, 3'd7);
    check("skip_err_after", {31'd0, err}, 0);
    check("skip_err_cnt_after", {28'd0, err_cnt}, 1);
`ifdef COUNT_SEQ_RESYNC_EN
    check("skip_locked", {31'd0, locked}, 1);
`else
    check("skip_locked", {31'd0, locked}, 0);
    step(1'b1, 3'd0);
    check("fault_no_pulse", {31'd0, err | wrap}, 0);
`endif

    // clr together with en and q=3: nothing sampled
    clr = 1'b1;
    step(1'b1, 3'd3);
    clr = 1'b0;
    check_all_zero("clr");
    nerr = 0;
    step(1'b1, 3'd4);
    check("clr_relock", {31'd0, locked}, 1);
    step(1'b1, 3'd5);
    check("clr_no_err", nerr, 0);
    check("clr_locked", {31'd0, locked}, 1);

    // stall at prev=5, q wanders while en=0
    step(1'b0, 3'd1);
    check("stall_err_low", {31'd0, err}, 0);
    step(1'b0, 3'd0);
    step(1'b0, 3'd7);
    step(1'b0, 3'd2);
    check("stall_err_cnt", {28'd0, err_cnt}, 0);
    check("stall_wrap_cnt", {24'd0, wrap_cnt}, 0);
    step(1'b1, 3'd6);
    step(1'b1, 3'd7);
    step(1'b1, 3'd0);
    check("stall_resume_err", nerr, 0);
    check("stall_resume_wrap", {24'd0, wrap_cnt}, 1);

    // q stuck at 2 for 20 enabled edges
    do_clr();
    nerr = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 3'd2);
`ifdef COUNT_SEQ_RESYNC_EN
    check("stuck_err_pulses", nerr, 19);
    check("stuck_err_cnt_sat", {28'd0, err_cnt}, 15);
    check("stuck_locked", {31'd0, locked}, 1);
`else
    check("stuck_err_pulses", nerr, 1);
    check("stuck_err_cnt", {28'd0, err_cnt}, 1);
    check("stuck_locked", {31'd0, locked}, 0);
`endif
    check("stuck_sticky", {31'd0, err_sticky}, 1);

    // async reset between edges
    do_clr();
    step(1'b1, 3'd6);
    step(1'b1, 3'd7);
    step(1'b1, 3'd0);
    check("pre_rst_wrap_cnt", {24'd0, wrap_cnt}, 1);
    step(1'b1, 3'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1;
    rst = 1'b0;
    nerr = 0;
    step(1'b1, 3'd4);
    check("post_rst_lock", {31'd0, locked}, 1);
    step(1'b1, 3'd5);
    check("post_rst_no_err", nerr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
